// File: rtl/icebus_pkg.sv
// Shared iCEbus definitions: frame magics, lengths, FSM state types and the CRC-16 step.
package icebus_pkg;

   localparam int unsigned MAGIC_NUMBER_LENGTH = 4;

   localparam logic [31:0] MAGIC_STATUS_REQUEST = 32'h1CE1CEBB;
   localparam logic [31:0] MAGIC_SETPOINT       = 32'hD0D0D0D0;
   localparam logic [31:0] MAGIC_CONTROL_MODE   = 32'hBAADA555;
   localparam logic [31:0] MAGIC_STATUS         = 32'h1CEB00DA;

   localparam int unsigned LEN_STATUS_REQUEST = 7;
   localparam int unsigned LEN_SETPOINT       = 13;
   localparam int unsigned LEN_CONTROL_MODE   = 28;
   localparam int unsigned LEN_STATUS         = 28;

   // Largest payload (everything after the magic) the slave has to buffer.
   localparam int unsigned MAX_PAYLOAD = LEN_CONTROL_MODE - MAGIC_NUMBER_LENGTH;

   typedef enum logic [2:0] {
      StHunt, StCollect, StCheck, StApply, StTurnaround, StBuild, StSend
   } state_t;

   typedef enum logic [1:0] {FrStatusRequest, FrSetpoint, FrControlMode} frame_t;

   typedef enum logic [1:0] {SerIdle, SerLoad, SerBusy} ser_state_t;

   // CRC-16, polynomial 0x1021, data MSB first.
   function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data, input logic [15:0] crc);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/icebus_frame_serializer.sv
// Streams a fixed-length byte frame into uart_tx: one start pulse per byte, advancing on the
// falling edge of tx_active.
module icebus_frame_serializer
   import icebus_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 28,
   localparam int unsigned IdxW = $clog2(FRAME_LEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      byte_data,
   output logic [IdxW-1:0] byte_index,
   input  logic            tx_active,
   output logic [7:0]      tx_data,
   output logic            tx_transmit,
   output logic            done
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

   ser_state_t      ser_q, ser_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [7:0]      data_d;
   logic            pulse_d;
   logic            active_q;

   assign byte_index = idx_q;

   always_comb begin
      ser_d   = ser_q;
      idx_d   = idx_q;
      data_d  = tx_data;
      pulse_d = 1'b0;
      done    = 1'b0;
      unique case (ser_q)
         SerIdle: begin
            if (start) begin
               idx_d = '0;
               ser_d = SerLoad;
            end
         end
         SerLoad: begin
            if (!tx_active) begin
               data_d  = byte_data;
               pulse_d = 1'b1;
               ser_d   = SerBusy;
            end
         end
         SerBusy: begin
            if (active_q && !tx_active) begin
               if (idx_q == LastIdx) begin
                  done  = 1'b1;
                  ser_d = SerIdle;
               end else begin
                  idx_d = idx_q + IdxW'(1);
                  ser_d = SerLoad;
               end
            end
         end
         default: ser_d = SerIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ser_q       <= SerIdle;
         idx_q       <= '0;
         tx_data     <= '0;
         tx_transmit <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         ser_q       <= ser_d;
         idx_q       <= idx_d;
         tx_data     <= data_d;
         tx_transmit <= pulse_d;
         active_q    <= tx_active;
      end
   end

endmodule

// File: rtl/icebus_slave_frame_handler.sv
// Slave end of the iCEbus link: parses request/setpoint/control frames for my_id, latches
// controller parameters and answers status requests with a CRC-protected status frame.
module icebus_slave_frame_handler
   import icebus_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ         = 50_000_000,
   parameter int unsigned BYTE_TIMEOUT_CYCLES = 50_000,
   parameter int unsigned TURNAROUND_CYCLES   = 1_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         my_id,
   input  logic               rx_data_ready,
   input  logic [7:0]         rx_data,
   output logic [7:0]         tx_data,
   output logic               tx_transmit,
   input  logic               tx_active,
   input  logic signed [23:0] encoder0_position,
   input  logic signed [23:0] encoder1_position,
   input  logic signed [23:0] duty,
   input  logic signed [23:0] displacement,
   input  logic signed [15:0] current,
   output logic [7:0]         control_mode,
   output logic signed [15:0] Kp,
   output logic signed [15:0] Ki,
   output logic signed [15:0] Kd,
   output logic signed [23:0] PWMLimit,
   output logic signed [23:0] IntegralLimit,
   output logic signed [23:0] deadband,
   output logic signed [23:0] setpoint,
   output logic signed [15:0] current_limit,
   output logic [23:0]        neopxl_color,
   output logic               params_updated,
   output logic [15:0]        crc_error_count,
   output logic [15:0]        timeout_count
);

   // An inter-byte gap longer than one second is never meaningful on this link.
   localparam int unsigned TimeoutCycles =
      (BYTE_TIMEOUT_CYCLES < CLK_FREQ_HZ) ? BYTE_TIMEOUT_CYCLES : CLK_FREQ_HZ;
   localparam int unsigned GapW = $clog2(TimeoutCycles + 1);
   localparam int unsigned TaW  = $clog2(TURNAROUND_CYCLES + 1);
   // Build step 0 snapshots, 1..22 run the CRC, 23 writes the CRC bytes.
   localparam logic [4:0]  BuildLast = 5'd23;

   state_t         state_q, state_d;
   frame_t         frame_q, frame_d;
   logic [23:0]    window_q;
   logic [31:0]    window_next;
   logic [4:0]     cnt_q, plen, build_q, ser_index;
   logic [7:0]     payload_q [MAX_PAYLOAD];
   logic [7:0]     reply_q [LEN_STATUS];
   logic [15:0]    crc_q;
   logic [GapW-1:0] gap_q;
   logic [TaW-1:0] ta_q;
   logic           crc_ok, timeout_hit, changed, ser_start, ser_done;

   logic [23:0] s_setpoint, s_color, c_pwm, c_il, c_db, c_setpoint;
   logic [15:0] c_kp, c_ki, c_kd, c_cl;
   logic [7:0]  c_mode;

   assign s_setpoint = {payload_q[1], payload_q[2], payload_q[3]};
   assign s_color    = {payload_q[4], payload_q[5], payload_q[6]};
   assign c_mode     = payload_q[1];
   assign c_kp       = {payload_q[2], payload_q[3]};
   assign c_ki       = {payload_q[4], payload_q[5]};
   assign c_kd       = {payload_q[6], payload_q[7]};
   assign c_pwm      = {payload_q[8], payload_q[9], payload_q[10]};
   assign c_il       = {payload_q[11], payload_q[12], payload_q[13]};
   assign c_db       = {payload_q[14], payload_q[15], payload_q[16]};
   assign c_setpoint = {payload_q[17], payload_q[18], payload_q[19]};
   assign c_cl       = {payload_q[20], payload_q[21]};

   always_comb begin
      unique case (frame_q)
         FrStatusRequest: plen = 5'(LEN_STATUS_REQUEST - MAGIC_NUMBER_LENGTH);
         FrSetpoint:      plen = 5'(LEN_SETPOINT - MAGIC_NUMBER_LENGTH);
         default:         plen = 5'(LEN_CONTROL_MODE - MAGIC_NUMBER_LENGTH);
      endcase
   end

   always_comb begin
      window_next = {window_q, rx_data};
      state_d     = state_q;
      frame_d     = frame_q;
      timeout_hit = 1'b0;
      ser_start   = 1'b0;
      crc_ok      = (crc_q == {payload_q[plen - 5'd2], payload_q[plen - 5'd1]});
      if (frame_q == FrSetpoint) begin
         changed = (s_setpoint != setpoint) || (s_color != neopxl_color);
      end else begin
         changed = (c_mode != control_mode) || (c_kp != Kp) || (c_ki != Ki) || (c_kd != Kd) ||
                   (c_pwm != PWMLimit) || (c_il != IntegralLimit) || (c_db != deadband) ||
                   (c_setpoint != setpoint) || (c_cl != current_limit);
      end
      unique case (state_q)
         StHunt: begin
            if (rx_data_ready) begin
               if (window_next == MAGIC_STATUS_REQUEST) begin
                  frame_d = FrStatusRequest;
                  state_d = StCollect;
               end else if (window_next == MAGIC_SETPOINT) begin
                  frame_d = FrSetpoint;
                  state_d = StCollect;
               end else if (window_next == MAGIC_CONTROL_MODE) begin
                  frame_d = FrControlMode;
                  state_d = StCollect;
               end
            end
         end
         StCollect: begin
            if (rx_data_ready) begin
               if (cnt_q == plen - 5'd1) state_d = StCheck;
            end else if (gap_q >= GapW'(TimeoutCycles)) begin
               timeout_hit = 1'b1;
               state_d     = StHunt;
            end
         end
         StCheck: begin
            if (!crc_ok || payload_q[0] != my_id) state_d = StHunt;
            else if (frame_q == FrStatusRequest)  state_d = StTurnaround;
            else                                  state_d = StApply;
         end
         StApply: state_d = StHunt;
         StTurnaround: begin
            if (ta_q == TaW'(TURNAROUND_CYCLES - 1)) state_d = StBuild;
         end
         StBuild: begin
            if (build_q == BuildLast) begin
               ser_start = 1'b1;
               state_d   = StSend;
            end
         end
         StSend: begin
            if (ser_done) state_d = StHunt;
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= StHunt;
         frame_q         <= FrStatusRequest;
         window_q        <= '0;
         cnt_q           <= '0;
         crc_q           <= '0;
         gap_q           <= '0;
         ta_q            <= '0;
         build_q         <= '0;
         for (int i = 0; i < MAX_PAYLOAD; i++) payload_q[i] <= '0;
         for (int i = 0; i < LEN_STATUS; i++) reply_q[i] <= '0;
         control_mode    <= '0;
         Kp              <= '0;
         Ki              <= '0;
         Kd              <= '0;
         PWMLimit        <= '0;
         IntegralLimit   <= '0;
         deadband        <= '0;
         setpoint        <= '0;
         current_limit   <= '0;
         neopxl_color    <= '0;
         params_updated  <= 1'b0;
         crc_error_count <= '0;
         timeout_count   <= '0;
      end else begin
         state_q        <= state_d;
         frame_q        <= frame_d;
         params_updated <= 1'b0;
         window_q       <= '0;
         unique case (state_q)
            StHunt: begin
               window_q <= rx_data_ready ? window_next[23:0] : window_q;
               if (state_d == StCollect) begin
                  cnt_q <= '0;
                  crc_q <= 16'hFFFF;
                  gap_q <= '0;
               end
            end
            StCollect: begin
               if (rx_data_ready) begin
                  payload_q[cnt_q] <= rx_data;
                  cnt_q            <= cnt_q + 5'd1;
                  gap_q            <= '0;
                  // The trailing two bytes are the received CRC and are stored raw.
                  if (cnt_q < plen - 5'd2) crc_q <= nextCRC16_D8(rx_data, crc_q);
               end else begin
                  gap_q <= gap_q + GapW'(1);
               end
               if (timeout_hit && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            end
            StCheck: begin
               ta_q    <= '0;
               build_q <= '0;
               if (!crc_ok && crc_error_count != 16'hFFFF) begin
                  crc_error_count <= crc_error_count + 16'd1;
               end
            end
            StApply: begin
               params_updated <= changed;
               if (frame_q == FrSetpoint) begin
                  setpoint     <= s_setpoint;
                  neopxl_color <= s_color;
               end else begin
                  control_mode  <= c_mode;
                  Kp            <= c_kp;
                  Ki            <= c_ki;
                  Kd            <= c_kd;
                  PWMLimit      <= c_pwm;
                  IntegralLimit <= c_il;
                  deadband      <= c_db;
                  setpoint      <= c_setpoint;
                  current_limit <= c_cl;
               end
            end
            StTurnaround: ta_q <= ta_q + TaW'(1);
            StBuild: begin
               build_q <= build_q + 5'd1;
               if (build_q == 5'd0) begin
                  reply_q[0]  <= MAGIC_STATUS[31:24];
                  reply_q[1]  <= MAGIC_STATUS[23:16];
                  reply_q[2]  <= MAGIC_STATUS[15:8];
                  reply_q[3]  <= MAGIC_STATUS[7:0];
                  reply_q[4]  <= my_id;
                  reply_q[5]  <= control_mode;
                  reply_q[6]  <= encoder0_position[23:16];
                  reply_q[7]  <= encoder0_position[15:8];
                  reply_q[8]  <= encoder0_position[7:0];
                  reply_q[9]  <= encoder1_position[23:16];
                  reply_q[10] <= encoder1_position[15:8];
                  reply_q[11] <= encoder1_position[7:0];
                  reply_q[12] <= setpoint[23:16];
                  reply_q[13] <= setpoint[15:8];
                  reply_q[14] <= setpoint[7:0];
                  reply_q[15] <= duty[23:16];
                  reply_q[16] <= duty[15:8];
                  reply_q[17] <= duty[7:0];
                  reply_q[18] <= displacement[23:16];
                  reply_q[19] <= displacement[15:8];
                  reply_q[20] <= displacement[7:0];
                  reply_q[21] <= current[15:8];
                  reply_q[22] <= current[7:0];
                  reply_q[23] <= neopxl_color[23:16];
                  reply_q[24] <= neopxl_color[15:8];
                  reply_q[25] <= neopxl_color[7:0];
                  crc_q       <= 16'hFFFF;
               end else if (build_q == BuildLast) begin
                  reply_q[26] <= crc_q[15:8];
                  reply_q[27] <= crc_q[7:0];
               end else begin
                  crc_q <= nextCRC16_D8(reply_q[build_q + 5'd3], crc_q);
               end
            end
            default: ;
         endcase
      end
   end

   icebus_frame_serializer #(
      .FRAME_LEN (LEN_STATUS)
   ) u_serializer (
      .clk         (clk),
      .reset       (reset),
      .start       (ser_start),
      .byte_data   (reply_q[ser_index]),
      .byte_index  (ser_index),
      .tx_active   (tx_active),
      .tx_data     (tx_data),
      .tx_transmit (tx_transmit),
      .done        (ser_done)
   );

endmodule

// File: tb/tb_icebus_slave_frame_handler.sv
// Directed bench for the iCEbus slave frame handler with a simple uart_tx stand-in.
module tb_icebus_slave_frame_handler;

   localparam int unsigned Timeout = 200;
   localparam int unsigned Turn    = 20;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [7:0]         my_id = 8'h05;
   logic               rx_data_ready = 1'b0;
   logic [7:0]         rx_data = '0;
   logic [7:0]         tx_data;
   logic               tx_transmit;
   logic               tx_active = 1'b0;
   logic signed [23:0] encoder0_position = 24'h123456;
   logic signed [23:0] encoder1_position = 24'hABCDEF;
   logic signed [23:0] duty = 24'h000F00;
   logic signed [23:0] displacement = 24'hFFFFFE;
   logic signed [15:0] current = 16'h0123;
   logic [7:0]         control_mode;
   logic signed [15:0] Kp, Ki, Kd, current_limit;
   logic signed [23:0] PWMLimit, IntegralLimit, deadband, setpoint;
   logic [23:0]        neopxl_color;
   logic               params_updated;
   logic [15:0]        crc_error_count, timeout_count;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int pu_count = 0;
   int overlap = 0;
   int busy = 0;
   int last_rx_cycle = 0;
   logic [7:0] tx_bytes[$];
   int         tx_cycles[$];
   logic [7:0] frm[$];

   icebus_slave_frame_handler #(
      .CLK_FREQ_HZ         (50_000_000),
      .BYTE_TIMEOUT_CYCLES (Timeout),
      .TURNAROUND_CYCLES   (Turn)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .my_id             (my_id),
      .rx_data_ready     (rx_data_ready),
      .rx_data           (rx_data),
      .tx_data           (tx_data),
      .tx_transmit       (tx_transmit),
      .tx_active         (tx_active),
      .encoder0_position (encoder0_position),
      .encoder1_position (encoder1_position),
      .duty              (duty),
      .displacement      (displacement),
      .current           (current),
      .control_mode      (control_mode),
      .Kp                (Kp),
      .Ki                (Ki),
      .Kd                (Kd),
      .PWMLimit          (PWMLimit),
      .IntegralLimit     (IntegralLimit),
      .deadband          (deadband),
      .setpoint          (setpoint),
      .current_limit     (current_limit),
      .neopxl_color      (neopxl_color),
      .params_updated    (params_updated),
      .crc_error_count   (crc_error_count),
      .timeout_count     (timeout_count)
   );

   always #5 clk = ~clk;

   // uart_tx stand-in: busy for 12 cycles after each start pulse.
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (params_updated) pu_count <= pu_count + 1;
      if (reset) begin
         busy      <= 0;
         tx_active <= 1'b0;
      end else if (tx_transmit) begin
         if (tx_active) overlap <= overlap + 1;
         tx_bytes.push_back(tx_data);
         tx_cycles.push_back(cycle);
         busy      <= 12;
         tx_active <= 1'b1;
      end else if (busy > 1) begin
         busy <= busy - 1;
      end else begin
         busy      <= 0;
         tx_active <= 1'b0;
      end
   end

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   task automatic start_frame(input logic [31:0] magic, input logic [7:0] id);
      frm.delete();
      frm.push_back(magic[31:24]);
      frm.push_back(magic[23:16]);
      frm.push_back(magic[15:8]);
      frm.push_back(magic[7:0]);
      frm.push_back(id);
   endtask

   task automatic push16(input logic [15:0] v);
      frm.push_back(v[15:8]);
      frm.push_back(v[7:0]);
   endtask

   task automatic push24(input logic [23:0] v);
      frm.push_back(v[23:16]);
      frm.push_back(v[15:8]);
      frm.push_back(v[7:0]);
   endtask

   task automatic finish_frame();
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 4; i < frm.size(); i++) c = crc_step(c, frm[i]);
      push16(c);
   endtask

   task automatic build_control(input logic [7:0] mode, input logic [15:0] kp, input logic [15:0] ki,
                                input logic [15:0] kd, input logic [23:0] pwm, input logic [23:0] il,
                                input logic [23:0] db, input logic [23:0] sp, input logic [15:0] cl);
      start_frame(32'hBAADA555, 8'h05);
      frm.push_back(mode);
      push16(kp);
      push16(ki);
      push16(kd);
      push24(pwm);
      push24(il);
      push24(db);
      push24(sp);
      push16(cl);
      finish_frame();
   endtask

   task automatic build_setpoint(input logic [23:0] sp, input logic [23:0] col);
      start_frame(32'hD0D0D0D0, 8'h05);
      push24(sp);
      push24(col);
      finish_frame();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data       = b;
      rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input int n);
      for (int i = 0; i < n; i++) send_byte(frm[i]);
      last_rx_cycle = cycle;
   endtask

   task automatic wait_tx(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_bytes.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (tx_transmit !== 1'b0) begin errors++; $display("FAIL reset_tx_transmit: got %b want 0", tx_transmit); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      checks++; if (control_mode !== 8'h00) begin errors++; $display("FAIL reset_mode: got %h want 00", control_mode); end
      checks++; if ({Kp, Ki, Kd, current_limit} !== 64'h0) begin errors++; $display("FAIL reset_gains: got %h want 0", {Kp, Ki, Kd, current_limit}); end
      checks++; if ({PWMLimit, IntegralLimit, deadband, setpoint} !== 96'h0) begin errors++; $display("FAIL reset_limits: got %h want 0", {PWMLimit, IntegralLimit, deadband, setpoint}); end
      checks++; if (neopxl_color !== 24'h0) begin errors++; $display("FAIL reset_color: got %h want 0", neopxl_color); end
      checks++; if (params_updated !== 1'b0) begin errors++; $display("FAIL reset_params_updated: got %b want 0", params_updated); end
      checks++; if ({crc_error_count, timeout_count} !== 32'h0) begin errors++; $display("FAIL reset_counters: got %h want 0", {crc_error_count, timeout_count}); end
   endtask

   task automatic test_status_request();
      int base;
      bit ok;
      logic [7:0] exp [28];
      logic [15:0] c;
      base = tx_bytes.size();
      start_frame(32'h1CE1CEBB, 8'h05);
      finish_frame();
      send_frame(frm.size());
      wait_tx(base + 28, 4000, ok);
      repeat (20) @(negedge clk);
      exp = '{8'h1C, 8'hEB, 8'h00, 8'hDA, 8'h05, 8'h00, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 8'h23,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      c = 16'hFFFF;
      for (int i = 4; i < 26; i++) c = crc_step(c, exp[i]);
      exp[26] = c[15:8];
      exp[27] = c[7:0];
      checks++;
      if (tx_bytes.size() - base != 28) begin
         errors++;
         $display("FAIL status_byte_count: got %0d want 28", tx_bytes.size() - base);
      end
      if (ok) begin
         for (int i = 0; i < 28; i++) begin
            checks++;
            if (tx_bytes[base + i] !== exp[i]) begin
               errors++;
               $display("FAIL status_byte_%0d: got %h want %h", i, tx_bytes[base + i], exp[i]);
            end
         end
         checks++;
         if (tx_cycles[base] - last_rx_cycle < Turn) begin
            errors++;
            $display("FAIL status_turnaround: got %0d cycles want >= %0d", tx_cycles[base] - last_rx_cycle, Turn);
         end
      end
      checks++; if (overlap !== 0) begin errors++; $display("FAIL status_overlap: got %0d want 0", overlap); end
   endtask

   task automatic test_control_mode();
      int pu0;
      pu0 = pu_count;
      build_control(8'h02, 16'h1234, 16'h0056, 16'hFF9C, 24'h0003E8, 24'h001000, 24'h000005,
                    24'hFFFF00, 16'h07D0);
      send_frame(frm.size());
      repeat (6) @(negedge clk);
      checks++; if (control_mode !== 8'h02) begin errors++; $display("FAIL ctl_mode: got %h want 02", control_mode); end
      checks++; if ({Kp, Ki, Kd} !== 48'h1234_0056_FF9C) begin errors++; $display("FAIL ctl_gains: got %h want 12340056ff9c", {Kp, Ki, Kd}); end
      checks++; if ({PWMLimit, IntegralLimit, deadband} !== 72'h0003E8_001000_000005) begin errors++; $display("FAIL ctl_limits: got %h want 0003e8001000000005", {PWMLimit, IntegralLimit, deadband}); end
      checks++; if (setpoint !== 24'hFFFF00) begin errors++; $display("FAIL ctl_setpoint: got %h want ffff00", setpoint); end
      checks++; if (current_limit !== 16'h07D0) begin errors++; $display("FAIL ctl_current_limit: got %h want 07d0", current_limit); end
      checks++; if (pu_count - pu0 !== 1) begin errors++; $display("FAIL ctl_params_updated: got %0d pulse cycles want 1", pu_count - pu0); end
   endtask

   task automatic test_setpoint();
      int pu0;
      pu0 = pu_count;
      build_setpoint(24'h000100, 24'hFF0000);
      send_frame(frm.size());
      repeat (6) @(negedge clk);
      checks++; if (setpoint !== 24'h000100) begin errors++; $display("FAIL sp_setpoint: got %h want 000100", setpoint); end
      checks++; if (neopxl_color !== 24'hFF0000) begin errors++; $display("FAIL sp_color: got %h want ff0000", neopxl_color); end
      checks++; if (Kp !== 16'h1234) begin errors++; $display("FAIL sp_kp_kept: got %h want 1234", Kp); end
      checks++; if (control_mode !== 8'h02) begin errors++; $display("FAIL sp_mode_kept: got %h want 02", control_mode); end
      checks++; if (pu_count - pu0 !== 1) begin errors++; $display("FAIL sp_params_updated: got %0d pulse cycles want 1", pu_count - pu0); end
   endtask

   task automatic test_crc_error();
      int pu0;
      pu0 = pu_count;
      build_control(8'h03, 16'h1111, 16'h2222, 16'h3333, 24'h444444, 24'h555555, 24'h666666,
                    24'h0ABCDE, 16'h7777);
      frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
      send_frame(frm.size());
      repeat (6) @(negedge clk);
      checks++; if (crc_error_count !== 16'd1) begin errors++; $display("FAIL crc_count: got %0d want 1", crc_error_count); end
      checks++; if ({control_mode, Kp} !== 24'h02_1234) begin errors++; $display("FAIL crc_no_apply: got %h want 021234", {control_mode, Kp}); end
      checks++; if (setpoint !== 24'h000100) begin errors++; $display("FAIL crc_setpoint_kept: got %h want 000100", setpoint); end
      checks++; if (pu_count - pu0 !== 0) begin errors++; $display("FAIL crc_params_updated: got %0d pulse cycles want 0", pu_count - pu0); end
   endtask

   task automatic test_wrong_id();
      int base;
      base = tx_bytes.size();
      start_frame(32'h1CE1CEBB, 8'h06);
      finish_frame();
      send_frame(frm.size());
      repeat (Turn + 150) @(negedge clk);
      checks++; if (tx_bytes.size() - base !== 0) begin errors++; $display("FAIL wrong_id_tx: got %0d pulses want 0", tx_bytes.size() - base); end
      checks++; if ({crc_error_count, timeout_count} !== {16'd1, 16'd0}) begin errors++; $display("FAIL wrong_id_counters: got %h want 00010000", {crc_error_count, timeout_count}); end
   endtask

   task automatic test_timeout();
      int pu0;
      build_control(8'h09, 16'h0909, 16'h0909, 16'h0909, 24'h090909, 24'h090909, 24'h090909,
                    24'h090909, 16'h0909);
      send_frame(10);
      repeat (Timeout + 100) @(negedge clk);
      checks++; if (timeout_count !== 16'd1) begin errors++; $display("FAIL timeout_count: got %0d want 1", timeout_count); end
      checks++; if (control_mode !== 8'h02) begin errors++; $display("FAIL timeout_no_apply: got %h want 02", control_mode); end
      pu0 = pu_count;
      build_setpoint(24'h000200, 24'h00FF00);
      send_frame(frm.size());
      repeat (6) @(negedge clk);
      checks++; if ({setpoint, neopxl_color} !== 48'h000200_00FF00) begin errors++; $display("FAIL timeout_recover: got %h want 00020000ff00", {setpoint, neopxl_color}); end
      checks++; if (pu_count - pu0 !== 1) begin errors++; $display("FAIL timeout_params_updated: got %0d want 1", pu_count - pu0); end
      checks++; if (crc_error_count !== 16'd1) begin errors++; $display("FAIL timeout_crc_count: got %0d want 1", crc_error_count); end
   endtask

   task automatic test_reset_mid_send();
      int base;
      bit ok;
      base = tx_bytes.size();
      start_frame(32'h1CE1CEBB, 8'h05);
      finish_frame();
      send_frame(frm.size());
      wait_tx(base + 12, 4000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midsend_reach_byte12: got %0d bytes want 12", tx_bytes.size() - base); end
      reset = 1'b1;
      #1;
      checks++; if (tx_transmit !== 1'b0) begin errors++; $display("FAIL midsend_tx_transmit: got %b want 0", tx_transmit); end
      checks++; if ({control_mode, Kp, setpoint, neopxl_color} !== 72'h0) begin errors++; $display("FAIL midsend_outputs: got %h want 0", {control_mode, Kp, setpoint, neopxl_color}); end
      checks++; if ({crc_error_count, timeout_count} !== 32'h0) begin errors++; $display("FAIL midsend_counters: got %h want 0", {crc_error_count, timeout_count}); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      base = tx_bytes.size();
      repeat (60) @(negedge clk);
      checks++; if (tx_bytes.size() - base !== 0) begin errors++; $display("FAIL midsend_tx_stopped: got %0d pulses want 0", tx_bytes.size() - base); end
      build_setpoint(24'h000300, 24'h0000FF);
      send_frame(frm.size());
      repeat (6) @(negedge clk);
      checks++; if ({setpoint, neopxl_color} !== 48'h000300_0000FF) begin errors++; $display("FAIL midsend_clean_hunt: got %h want 0003000000ff", {setpoint, neopxl_color}); end
      checks++; if (Kp !== 16'h0000) begin errors++; $display("FAIL midsend_kp: got %h want 0000", Kp); end
   endtask

   initial begin
      test_reset();
      test_status_request();
      test_control_mode();
      test_setpoint();
      test_crc_error();
      test_wrong_id();
      test_timeout();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
